// File: rtl/add_slice_sequencer.sv
// rtl/add_slice_sequencer.sv - wide add/sub sequencer time-sharing one external adder slice
module add_slice_sequencer #(
    parameter int SLICE_W    = 16,
    parameter int NUM_SLICES = 2,
    localparam int W         = SLICE_W * NUM_SLICES,
    localparam int IDX_W     = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sub,
    input  logic [W-1:0]       in_a,
    input  logic [W-1:0]       in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_result,
    output logic               out_carry,
    output logic               out_ovf,
    output logic               out_zero,
    output logic [SLICE_W-1:0] adder_a,
    output logic [SLICE_W-1:0] adder_b,
    output logic               adder_cin,
    input  logic [SLICE_W-1:0] adder_sum,
    input  logic               adder_cout,
    input  logic               adder_clastin
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic               sub_reg;
    logic               carry_reg;
    logic [W-1:0]       result_reg;
    logic               carry_out_reg;
    logic               ovf_reg;
    logic               last_chunk;

    assign last_chunk = (idx == IDX_W'(NUM_SLICES - 1));
    assign out_result = result_reg;
    assign out_carry  = carry_out_reg;
    assign out_ovf    = ovf_reg;
    assign out_zero   = (result_reg == '0);

    // State register; reset wins over any handshake at the same edge
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshake outputs and slice drive (slice inputs idle at 0 outside RUN)
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        adder_a    = '0;
        adder_b    = '0;
        adder_cin  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                adder_a   = a_reg[idx*SLICE_W +: SLICE_W];
                adder_b   = b_reg[idx*SLICE_W +: SLICE_W] ^ {SLICE_W{sub_reg}};
                adder_cin = carry_reg;
                if (last_chunk) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, chunk sequencing, carry chaining and final flag capture
    always_ff @(posedge clock) begin
        if (reset) begin
            idx           <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            sub_reg       <= 1'b0;
            carry_reg     <= 1'b0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        sub_reg   <= in_sub;
                        idx       <= '0;
                        // Subtraction is A + ~B + 1, so the +1 rides in as the first carry
                        carry_reg <= in_sub;
                    end
                end
                S_RUN: begin
                    result_reg[idx*SLICE_W +: SLICE_W] <= adder_sum;
                    carry_reg <= adder_cout;
                    if (last_chunk) begin
                        carry_out_reg <= adder_cout;
                        // Signed overflow: carry into MSB differs from carry out of MSB
                        ovf_reg       <= adder_cout ^ adder_clastin;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_slice_sequencer.sv
// tb/tb_add_slice_sequencer.sv - randomized self-checking bench for add_slice_sequencer
module tb_add_slice_sequencer;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    logic sel;

    function automatic logic [17:0] slice_model(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [16:0] s;
        logic [15:0] lo;
        s  = {1'b0, a} + {1'b0, b} + {16'b0, cin};
        lo = {1'b0, a[14:0]} + {1'b0, b[14:0]} + {15'b0, cin};
        return {lo[15], s[16], s[15:0]};
    endfunction

    logic        d2_in_valid, d2_in_sub, d2_out_ready;
    logic [31:0] d2_in_a, d2_in_b, d2_out_result;
    logic        d2_in_ready, d2_out_valid, d2_out_carry, d2_out_ovf, d2_out_zero;
    logic [15:0] d2_adder_a, d2_adder_b, d2_adder_sum;
    logic        d2_adder_cin, d2_adder_cout, d2_adder_clastin;

    logic        d4_in_valid, d4_in_sub, d4_out_ready;
    logic [63:0] d4_in_a, d4_in_b, d4_out_result;
    logic        d4_in_ready, d4_out_valid, d4_out_carry, d4_out_ovf, d4_out_zero;
    logic [15:0] d4_adder_a, d4_adder_b, d4_adder_sum;
    logic        d4_adder_cin, d4_adder_cout, d4_adder_clastin;

    assign {d2_adder_clastin, d2_adder_cout, d2_adder_sum} = slice_model(d2_adder_a, d2_adder_b, d2_adder_cin);
    assign {d4_adder_clastin, d4_adder_cout, d4_adder_sum} = slice_model(d4_adder_a, d4_adder_b, d4_adder_cin);

    add_slice_sequencer #(.SLICE_W(16), .NUM_SLICES(2)) dut2 (
        .clock(clock), .reset(reset),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_sub(d2_in_sub),
        .in_a(d2_in_a), .in_b(d2_in_b),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_result(d2_out_result),
        .out_carry(d2_out_carry), .out_ovf(d2_out_ovf), .out_zero(d2_out_zero),
        .adder_a(d2_adder_a), .adder_b(d2_adder_b), .adder_cin(d2_adder_cin),
        .adder_sum(d2_adder_sum), .adder_cout(d2_adder_cout), .adder_clastin(d2_adder_clastin)
    );

    add_slice_sequencer #(.SLICE_W(16), .NUM_SLICES(4)) dut4 (
        .clock(clock), .reset(reset),
        .in_valid(d4_in_valid), .in_ready(d4_in_ready), .in_sub(d4_in_sub),
        .in_a(d4_in_a), .in_b(d4_in_b),
        .out_valid(d4_out_valid), .out_ready(d4_out_ready), .out_result(d4_out_result),
        .out_carry(d4_out_carry), .out_ovf(d4_out_ovf), .out_zero(d4_out_zero),
        .adder_a(d4_adder_a), .adder_b(d4_adder_b), .adder_cin(d4_adder_cin),
        .adder_sum(d4_adder_sum), .adder_cout(d4_adder_cout), .adder_clastin(d4_adder_clastin)
    );

    wire        o_in_ready  = sel ? d4_in_ready  : d2_in_ready;
    wire        o_out_valid = sel ? d4_out_valid : d2_out_valid;
    wire [63:0] o_result    = sel ? d4_out_result : {32'b0, d2_out_result};
    wire        o_carry     = sel ? d4_out_carry : d2_out_carry;
    wire        o_ovf       = sel ? d4_out_ovf   : d2_out_ovf;
    wire        o_zero      = sel ? d4_out_zero  : d2_out_zero;
    wire [15:0] o_adder_a   = sel ? d4_adder_a   : d2_adder_a;
    wire [15:0] o_adder_b   = sel ? d4_adder_b   : d2_adder_b;
    wire        o_adder_cin = sel ? d4_adder_cin : d2_adder_cin;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic sub, input logic [63:0] a, input logic [63:0] b, input logic rdy);
        d2_in_valid  = !sel && v;
        d4_in_valid  = sel && v;
        d2_in_sub    = sub;
        d4_in_sub    = sub;
        d2_in_a      = a[31:0];
        d2_in_b      = b[31:0];
        d4_in_a      = a;
        d4_in_b      = b;
        d2_out_ready = !sel && rdy;
        d4_out_ready = sel && rdy;
    endtask

    function automatic logic [63:0] width_mask(input logic wide);
        return wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    // Reference: {ovf, carry, result} of the W-bit two's-complement operation
    function automatic logic [65:0] model(input logic wide, input logic sub, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mask, am, bm, r;
        logic [64:0] full;
        logic        c, v, sa, sb, sr;
        int          w;
        w    = wide ? 64 : 32;
        mask = width_mask(wide);
        am   = a & mask;
        bm   = b & mask;
        full = {1'b0, am} + {1'b0, (sub ? ~bm : bm) & mask} + {64'b0, sub};
        r    = full[63:0] & mask;
        c    = full[w];
        sa   = am[w-1];
        sb   = bm[w-1];
        sr   = r[w-1];
        v    = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        return {v, c, r};
    endfunction

    // Carry entering 16-bit chunk k of the full-width operation
    function automatic logic chunk_cin(input logic sub, input logic [63:0] a, input logic [63:0] b, input int k);
        logic [64:0] low, full, bb;
        if (k == 0) return sub;
        low  = (65'd1 << (16 * k)) - 65'd1;
        bb   = {1'b0, sub ? ~b : b};
        full = ({1'b0, a} & low) + (bb & low) + {64'b0, sub};
        return full[16*k];
    endfunction

    task automatic check_idle(input string tag);
        #1;
        check({tag, " in_ready"},  {63'b0, o_in_ready}, 64'd1);
        check({tag, " out_valid"}, {63'b0, o_out_valid}, 64'd0);
        check({tag, " result"},    o_result, 64'd0);
        check({tag, " carry"},     {63'b0, o_carry}, 64'd0);
        check({tag, " ovf"},       {63'b0, o_ovf}, 64'd0);
        check({tag, " zero"},      {63'b0, o_zero}, 64'd1);
        check({tag, " adder_a"},   {48'b0, o_adder_a}, 64'd0);
        check({tag, " adder_b"},   {48'b0, o_adder_b}, 64'd0);
        check({tag, " adder_cin"}, {63'b0, o_adder_cin}, 64'd0);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One full operation on the selected DUT; entered and left at a negedge in IDLE
    task automatic do_op(input logic sub, input logic [63:0] a_in, input logic [63:0] b_in, input int hold, input string tag);
        int          n;
        logic [63:0] a, b, bx;
        logic [65:0] m;
        n  = sel ? 4 : 2;
        a  = a_in & width_mask(sel);
        b  = b_in & width_mask(sel);
        bx = b ^ {64{sub}};
        m  = model(sel, sub, a, b);
        check({tag, " ready before"}, {63'b0, o_in_ready}, 64'd1);
        drive(1'b1, sub, a, b, 1'b0);
        @(negedge clock);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s run%0d out_valid", tag, k), {63'b0, o_out_valid}, 64'd0);
            check($sformatf("%s run%0d in_ready", tag, k), {63'b0, o_in_ready}, 64'd0);
            check($sformatf("%s run%0d adder_a", tag, k), {48'b0, o_adder_a}, {48'b0, a[16*k +: 16]});
            check($sformatf("%s run%0d adder_b", tag, k), {48'b0, o_adder_b}, {48'b0, bx[16*k +: 16]});
            check($sformatf("%s run%0d adder_cin", tag, k), {63'b0, o_adder_cin}, {63'b0, chunk_cin(sub, a, b, k)});
            drive(1'($urandom % 2), 1'($urandom % 2), rnd64(), rnd64(), 1'($urandom % 2));
            @(negedge clock);
        end
        for (int h = 0; h <= hold; h++) begin
            check($sformatf("%s done%0d out_valid", tag, h), {63'b0, o_out_valid}, 64'd1);
            check($sformatf("%s done%0d in_ready", tag, h), {63'b0, o_in_ready}, 64'd0);
            check($sformatf("%s done%0d result", tag, h), o_result, m[63:0]);
            check($sformatf("%s done%0d carry", tag, h), {63'b0, o_carry}, {63'b0, m[64]});
            check($sformatf("%s done%0d ovf", tag, h), {63'b0, o_ovf}, {63'b0, m[65]});
            check($sformatf("%s done%0d zero", tag, h), {63'b0, o_zero}, {63'b0, (m[63:0] == 64'd0)});
            check($sformatf("%s done%0d adder_cin", tag, h), {63'b0, o_adder_cin}, 64'd0);
            // Alternate in_valid while blocked, then hand off with a request pending
            drive((h % 2) == 0 ? 1'b1 : 1'b0, 1'($urandom % 2), rnd64(), rnd64(), h == hold);
            @(negedge clock);
        end
        check({tag, " after handoff out_valid"}, {63'b0, o_out_valid}, 64'd0);
        check({tag, " after handoff in_ready"}, {63'b0, o_in_ready}, 64'd1);
        drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom % 5)
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return sel ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
            3: return sel ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h0000_0000_7FFF_FFFF;
            default: return rnd64();
        endcase
    endfunction

    initial begin
        sel   = 1'b0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        d4_in_valid = 1'b0;
        d4_out_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_idle("reset dut2");
        sel = 1'b1;
        check_idle("reset dut4");
        sel = 1'b0;
        @(negedge clock);

        do_op(1'b0, 64'h0000FFFF, 64'h1, 0, "add carry chain");
        do_op(1'b1, 64'd5, 64'd7, 0, "sub borrow");
        do_op(1'b0, 64'h7FFFFFFF, 64'h1, 1, "add ovf");
        do_op(1'b1, 64'h80000000, 64'h1, 0, "sub ovf");
        do_op(1'b1, 64'h12345678, 64'h12345678, 2, "sub zero");
        do_op(1'b0, 64'hDEADBEEF, 64'h01020304, 4, "backpressure");
        do_op(1'b1, 64'h00001000, 64'h00000FFF, 0, "after backpressure");

        drive(1'b1, 1'b0, 64'h00FF00FF, 64'h0F0F0F0F, 1'b0);
        @(negedge clock);
        drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_idle("reset mid run");
        @(negedge clock);
        do_op(1'b0, 64'd1, 64'd1, 0, "add after reset");

        sel = 1'b1;
        @(negedge clock);
        do_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, "w64 wrap");
        do_op(1'b1, 64'h8000_0000_0000_0000, 64'd1, 1, "w64 sub ovf");

        for (int i = 0; i < 24; i++) begin
            sel = 1'($urandom % 2);
            @(negedge clock);
            do_op(1'($urandom % 2), pick_operand(), pick_operand(), int'($urandom % 4), $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
